// File: rtl/soc_system_switch_poller.sv
// Avalon-MM master that polls a switch PIO slave (edge capture + levels) on a
// timer or interrupt and hands each non-empty capture to a consumer as an event.
module soc_system_switch_poller #(
   parameter int unsigned       WIDTH         = 10,
   parameter int unsigned       POLL_DIV      = 1000,
   parameter int unsigned       READ_LATENCY  = 1,
   parameter logic [WIDTH-1:0]  IRQ_MASK_INIT = '1
) (
   input  logic             clk,
   input  logic             reset_n,
   output logic [1:0]       avm_address,
   output logic             avm_read,
   output logic             avm_write,
   output logic [31:0]      avm_writedata,
   input  logic [31:0]      avm_readdata,
   input  logic             avm_waitrequest,
   input  logic             irq_in,
   input  logic             enable,
   output logic [WIDTH-1:0] sw_value,
   output logic [WIDTH-1:0] sw_changed,
   output logic             event_valid,
   input  logic             event_ready
);

   // state     | meaning
   // INIT      | write IRQ_MASK_INIT to the mask register
   // IDLE      | poll timer running (when enabled), waiting for timer or irq
   // RD_CAP    | read of edge-capture register pending acceptance
   // WAIT_CAP  | read latency, then sample capture bits
   // WR_CLR    | write 0 to edge-capture register
   // RD_DATA   | read of data register pending acceptance
   // WAIT_DATA | read latency, then sample switch levels
   // EVENT     | event_valid high until event_ready
   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_RD_CAP, S_WAIT_CAP, S_WR_CLR, S_RD_DATA, S_WAIT_DATA, S_EVENT
   } state_t;

   localparam int unsigned      CNT_W       = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
   localparam logic [CNT_W-1:0] POLL_RELOAD = CNT_W'(POLL_DIV - 1);
   localparam logic [1:0]       LAT_RELOAD  = 2'(READ_LATENCY - 1);
   localparam logic [1:0]       ADDR_DATA   = 2'd0;
   localparam logic [1:0]       ADDR_MASK   = 2'd2;
   localparam logic [1:0]       ADDR_CAP    = 2'd3;

   state_t           state_q;
   logic [CNT_W-1:0] poll_cnt_q;
   logic [1:0]       lat_cnt_q;
   logic             read_q;
   logic             write_q;
   logic [1:0]       addr_q;
   logic [31:0]      wdata_q;
   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] changed_q;
   logic             valid_q;

   logic             accepted;
   logic [WIDTH-1:0] rd_bits;
   logic             rd_unused;

   assign accepted  = (read_q | write_q) & ~avm_waitrequest;
   assign rd_bits   = avm_readdata[WIDTH-1:0];
   // upper read-data bits carry nothing this block needs
   assign rd_unused = ^avm_readdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_INIT;
         poll_cnt_q <= POLL_RELOAD;
         lat_cnt_q  <= '0;
         read_q     <= 1'b0;
         write_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         value_q    <= '0;
         changed_q  <= '0;
         valid_q    <= 1'b0;
      end else begin
         case (state_q)
            S_INIT: begin
               if (!write_q) begin
                  write_q <= 1'b1;
                  addr_q  <= ADDR_MASK;
                  wdata_q <= 32'(IRQ_MASK_INIT);
               end else if (accepted) begin
                  write_q <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (enable) begin
                  if (poll_cnt_q == '0 || irq_in) begin
                     poll_cnt_q <= POLL_RELOAD;
                     read_q     <= 1'b1;
                     addr_q     <= ADDR_CAP;
                     state_q    <= S_RD_CAP;
                  end else begin
                     poll_cnt_q <= poll_cnt_q - CNT_W'(1);
                  end
               end
            end
            S_RD_CAP: begin
               if (accepted) begin
                  read_q    <= 1'b0;
                  lat_cnt_q <= LAT_RELOAD;
                  state_q   <= S_WAIT_CAP;
               end
            end
            S_WAIT_CAP: begin
               if (lat_cnt_q != '0) begin
                  lat_cnt_q <= lat_cnt_q - 2'd1;
               end else if (rd_bits == '0) begin
                  state_q <= S_IDLE;
               end else begin
                  changed_q <= rd_bits;
                  write_q   <= 1'b1;
                  addr_q    <= ADDR_CAP;
                  wdata_q   <= '0;
                  state_q   <= S_WR_CLR;
               end
            end
            S_WR_CLR: begin
               if (accepted) begin
                  write_q <= 1'b0;
                  read_q  <= 1'b1;
                  addr_q  <= ADDR_DATA;
                  state_q <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (accepted) begin
                  read_q    <= 1'b0;
                  lat_cnt_q <= LAT_RELOAD;
                  state_q   <= S_WAIT_DATA;
               end
            end
            S_WAIT_DATA: begin
               if (lat_cnt_q != '0) begin
                  lat_cnt_q <= lat_cnt_q - 2'd1;
               end else begin
                  value_q <= rd_bits;
                  valid_q <= 1'b1;
                  state_q <= S_EVENT;
               end
            end
            S_EVENT: begin
               if (event_ready) begin
                  valid_q <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_INIT;
         endcase
      end
   end

   assign avm_address   = addr_q;
   assign avm_read      = read_q;
   assign avm_write     = write_q;
   assign avm_writedata = wdata_q;
   assign sw_value      = value_q;
   assign sw_changed    = changed_q;
   assign event_valid   = valid_q;

endmodule

// File: doc/soc_system_switch_poller.md
SOC_SYSTEM_SWITCH_POLLER -- requirements
Module: soc_system_switch_poller

Interface
REQ-001: Parameter WIDTH, default 10, number of switch bits handled.
REQ-002: Parameter POLL_DIV, default 1000, clock cycles between timer-driven polls (minimum 2).
REQ-003: Parameter READ_LATENCY, default 1, cycles from read acceptance to valid avm_readdata (1..4).
REQ-004: Parameter IRQ_MASK_INIT, default all ones (WIDTH bits), value written to the slave's interrupt-mask register after reset.
REQ-005: clk  input  1  sole clock; all state on rising edge.
REQ-006: reset_n  input  1  asynchronous, active-low reset.
REQ-007: avm_address  output  2  word address to the switch PIO slave (0 = data, 2 = irq mask, 3 = edge capture).
REQ-008: avm_read  output  1  read request.
REQ-009: avm_write  output  1  write request.
REQ-010: avm_writedata  output  32  write data.
REQ-011: avm_readdata  input  32  read data, valid READ_LATENCY cycles after acceptance.
REQ-012: avm_waitrequest  input  1  slave stall; tie to 0 for a zero-wait slave.
REQ-013: irq_in  input  1  interrupt from the switch PIO slave.
REQ-014: enable  input  1  polling enable.
REQ-015: sw_value  output  WIDTH  latest switch levels read from address 0.
REQ-016: sw_changed  output  WIDTH  edge-capture bits that produced the current event.
REQ-017: event_valid  output  1  event available on sw_value/sw_changed.
REQ-018: event_ready  input  1  consumer accepts event.

Function
REQ-019: A command SHALL be accepted on the cycle avm_read or avm_write is high and avm_waitrequest is low; address, read/write and writedata SHALL be held stable until acceptance.
REQ-020: avm_read and avm_write SHALL never both be high; at most one transaction outstanding.
REQ-021: Read data SHALL be sampled exactly READ_LATENCY cycles after the acceptance cycle, counted by an internal counter.
REQ-022: States: INIT, IDLE, RD_CAP, WAIT_CAP, WR_CLR, RD_DATA, WAIT_DATA, EVENT.
REQ-023: INIT (entered from reset) SHALL write IRQ_MASK_INIT (zero-extended) to address 2, then go to IDLE on acceptance.
REQ-024: In IDLE with enable high, a poll counter SHALL count down from POLL_DIV-1; a poll starts when it reaches 0 or irq_in is high, whichever first; simultaneous timer expiry and irq_in start one poll.
REQ-025: Poll counter SHALL reload to POLL_DIV-1 on leaving IDLE and hold while enable is low.
REQ-026: RD_CAP reads address 3; WAIT_CAP samples edge capture bits [WIDTH-1:0]; zero -> IDLE, nonzero -> store in sw_changed, go to WR_CLR.
REQ-027: WR_CLR SHALL write 32'h0 to address 3 (clears capture), then RD_DATA reads address 0; WAIT_DATA loads sw_value from bits [WIDTH-1:0] and goes to EVENT.
REQ-028: EVENT SHALL hold event_valid high with stable sw_value/sw_changed until event_ready is high, then return to IDLE next cycle; event_ready while event_valid low SHALL be ignored.
REQ-029: No new poll SHALL start while an event is pending (backpressure); edges meanwhile remain in the slave's capture register.
REQ-030: enable deasserted mid-poll SHALL NOT abort the poll; it completes through EVENT, then remains in IDLE.
REQ-031: avm_readdata bits above WIDTH SHALL be ignored.

Reset
REQ-032: While reset_n low: avm_read, avm_write, event_valid = 0; avm_address = 0; avm_writedata = 0; sw_value, sw_changed = 0; poll counter = POLL_DIV-1; state = INIT.
REQ-033: Reset mid-transaction SHALL deassert avm_read/avm_write immediately (asynchronously) and discard any pending read data.

Verification
REQ-034: Reset release, waitrequest=0 -> first command: write addr 2, data 0x3FF; then IDLE, no further bus activity for POLL_DIV-1 cycles.
REQ-035: Timer poll with capture=0 -> single read of addr 3, returns to IDLE, no write, event_valid stays 0.
REQ-036: irq_in=1, capture=0x005, data=0x2A5 -> read 3, write 3 (0x0), read 0; event_valid=1, sw_changed=0x005, sw_value=0x2A5.
REQ-037: event_ready held 0 for 5000 cycles with irq_in high -> event held stable, no bus commands issued; event_ready=1 -> IDLE next cycle.
REQ-038: avm_waitrequest high 3 cycles on each command, READ_LATENCY=2 -> commands held stable until accepted, data sampled 2 cycles after acceptance, results as REQ-036.
REQ-039: reset_n pulsed low during WAIT_DATA -> all outputs per REQ-032, sequence restarts at INIT write.
